// File: rtl/multicycle_ctrl.sv
// Main controller for the multicycle MIPS datapath.
// Sequences one instruction over 3-5 cycles from Op/Funct and drives all
// datapath strobes and mux selects. Also keeps a retired-instruction counter
// and exposes the state code for the board display.
module multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Run,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   output logic             IorD,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemToReg,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             PCEn,
   output logic             ExtOp,
   output logic [2:0]       ALUCtl,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      IEXEC  = 4'd9,
      IWB    = 4'd10,
      JUMP   = 4'd11
   } stateT;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   stateT state;

   // State sequencing and retired-instruction counting.
   always_ff @(posedge CLK or negedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!Reset) begin
         state      <= FETCH;
         InstrCount <= '0;
      end else begin
         // Terminal states retire the instruction on the edge leaving them.
         case (state)
            MEMWB, MEMWR, ALUWB, BRANCH, IWB, JUMP:
               InstrCount <= InstrCount + CNT_ONE;
            default: ;
         endcase

         case (state)
            FETCH:   if (Run) state <= DECODE;
            DECODE: begin
               case (Op)
                  OP_LW, OP_SW:                        state <= MEMADR;
                  OP_R:                                state <= EXEC;
                  OP_BEQ, OP_BNE:                      state <= BRANCH;
                  OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state <= IEXEC;
                  OP_J:                                state <= JUMP;
                  default:                             state <= FETCH;
               endcase
            end
            MEMADR:  state <= (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state <= MEMWB;
            EXEC:    state <= ALUWB;
            IEXEC:   state <= IWB;
            default: state <= FETCH;
         endcase
      end
   end

   assign State = state;

   // Strobe and mux-select decode from the current state (Zero only in BRANCH,
   // Run only in FETCH); everything is forced low while Reset is held.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      ALUSrcA  = 1'b0;
      RegWrite = 1'b0;
      PCEn     = 1'b0;
      ExtOp    = 1'b0;
      ALUCtl   = 3'b000;
      ALUSrcB  = 2'b00;
      PCSrc    = 2'b00;
      if (Reset) begin
         case (state)
            FETCH: begin
               if (Run) begin
                  IRWrite = 1'b1;
                  ALUSrcB = 2'b01;
                  ALUCtl  = ALU_ADD;
                  PCEn    = 1'b1;
               end
            end
            DECODE: begin
               // Branch target precomputed into ALUOut.
               ALUSrcB = 2'b11;
               ALUCtl  = ALU_ADD;
               ExtOp   = 1'b1;
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUCtl  = ALU_ADD;
               ExtOp   = 1'b1;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
               MemToReg = 1'b1;
               RegWrite = 1'b1;
            end
            MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               case (Funct)
                  6'b100010: ALUCtl = ALU_SUB;
                  6'b100100: ALUCtl = ALU_AND;
                  6'b100101: ALUCtl = ALU_OR;
                  6'b101010: ALUCtl = ALU_SLT;
                  default:   ALUCtl = ALU_ADD;
               endcase
            end
            ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            BRANCH: begin
               ALUSrcA = 1'b1;
               ALUCtl  = ALU_SUB;
               PCSrc   = 2'b01;
               PCEn    = (Op == OP_BEQ) ? Zero : ~Zero;
            end
            IEXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (Op)
                  OP_SLTI: begin
                     ALUCtl = ALU_SLT;
                     ExtOp  = 1'b1;
                  end
                  OP_ANDI: ALUCtl = ALU_AND;
                  OP_ORI:  ALUCtl = ALU_OR;
                  default: begin
                     ALUCtl = ALU_ADD;
                     ExtOp  = 1'b1;
                  end
               endcase
            end
            IWB: RegWrite = 1'b1;
            JUMP: begin
               PCSrc = 2'b10;
               PCEn  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
